wb_arbiter: RTL and testbench

//  Write-back arbiter feeding the single write port of regfile (enable/wreg/wdata).

---
 rtl/wb_arbiter_pkg.sv | 15 +
 rtl/wb_queue.sv | 79 +++++++
 rtl/wb_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the write-back arbiter: which source owns the regfile
// write port in a given cycle.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    SRC_IDLE  = 2'd0,
    SRC_PIPE  = 2'd1,
    SRC_QUEUE = 2'd2
  } wb_src_e;

  function automatic logic is_live_reg(input logic [31:0] wreg);
    return wreg != 32'd0;
  endfunction

endpackage

// File: rtl/wb_queue.sv
// Long-latency result queue: FIFO with a per-entry valid bit, squash of all
// entries targeting a given register, and a CAM-style match for hazard lookup.
module wb_queue #(
  parameter int WIDTH  = 32,
  parameter int ADDR   = 5,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [ADDR-1:0]  push_wreg,
  input  logic [WIDTH-1:0] push_wdata,
  input  logic             pop,
  input  logic             squash,
  input  logic [ADDR-1:0]  squash_wreg,
  input  logic [ADDR-1:0]  match_wreg,
  output logic             empty,
  output logic             full,
  output logic             head_valid,
  output logic [ADDR-1:0]  head_wreg,
  output logic [WIDTH-1:0] head_wdata,
  output logic             any_valid,
  output logic             match
);

  localparam int PW = $clog2(QDEPTH);

  logic [QDEPTH-1:0] valid_q;
  logic [ADDR-1:0]   wreg_q  [QDEPTH];
  logic [WIDTH-1:0]  wdata_q [QDEPTH];
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [PW:0]       count_q;
  logic              push_ok;
  logic              pop_ok;

  assign empty      = (count_q == '0);
  assign full       = (count_q == (PW+1)'(QDEPTH));
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign head_valid = valid_q[head_q];
  assign head_wreg  = wreg_q[head_q];
  assign head_wdata = wdata_q[head_q];
  assign any_valid  = |valid_q;

  // Storage update: squash existing entries first, so a same-cycle push survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (squash && wreg_q[i] == squash_wreg) valid_q[i] <= 1'b0;
      end
      if (pop_ok) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (push_ok) begin
        valid_q[tail_q] <= 1'b1;
        wreg_q[tail_q]  <= push_wreg;
        wdata_q[tail_q] <= push_wdata;
        tail_q          <= tail_q + PW'(1);
      end
      count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end

  // Pending-write lookup across all live entries.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (valid_q[i] && wreg_q[i] == match_wreg) match = 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges in-order pipeline results with queued
// long-latency results onto the single regfile write port, with a starvation
// stall so the queue always drains eventually.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int WIDTH        = 32,
  parameter  int DEPTH        = 32,
  parameter  int QDEPTH       = 4,
  parameter  int STARVE_LIMIT = 8,
  localparam int ADDR         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_we,
  input  logic [ADDR-1:0]  pipe_wreg,
  input  logic [WIDTH-1:0] pipe_wdata,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [ADDR-1:0]  lu_wreg,
  input  logic [WIDTH-1:0] lu_wdata,
  input  logic [ADDR-1:0]  pend_qreg,
  output logic             pend_hit,
  output logic             stall_req,
  output logic             rf_enable,
  output logic [ADDR-1:0]  rf_wreg,
  output logic [WIDTH-1:0] rf_wdata
);

  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  wb_src_e          src;
  logic             pipe_live;
  logic             q_empty;
  logic             q_full;
  logic             q_head_valid;
  logic [ADDR-1:0]  q_head_wreg;
  logic [WIDTH-1:0] q_head_wdata;
  logic             q_any_valid;
  logic             q_match;
  logic             q_push;
  logic [SW-1:0]    starve_q;

  assign pipe_live = pipe_we && is_live_reg(32'(pipe_wreg));
  assign lu_ready  = !reset && !q_full;
  assign q_push    = lu_valid && lu_ready && is_live_reg(32'(lu_wreg));
  assign pend_hit  = !reset && is_live_reg(32'(pend_qreg)) &&
                     (q_match || (rf_enable && rf_wreg == pend_qreg));

  // Port owner for this cycle; a pending stall forces the queue ahead of the pipe.
  always_comb begin
    src = SRC_IDLE;
    if (stall_req) begin
      if (!q_empty) src = SRC_QUEUE;
    end else if (pipe_live) begin
      src = SRC_PIPE;
    end else if (!q_empty) begin
      src = SRC_QUEUE;
    end
  end

  wb_queue #(
    .WIDTH  (WIDTH),
    .ADDR   (ADDR),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push        (q_push),
    .push_wreg   (lu_wreg),
    .push_wdata  (lu_wdata),
    .pop         (src == SRC_QUEUE),
    .squash      (src == SRC_PIPE),
    .squash_wreg (pipe_wreg),
    .match_wreg  (pend_qreg),
    .empty       (q_empty),
    .full        (q_full),
    .head_valid  (q_head_valid),
    .head_wreg   (q_head_wreg),
    .head_wdata  (q_head_wdata),
    .any_valid   (q_any_valid),
    .match       (q_match)
  );

  // Register the winning write and track how long live queue entries have waited.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_enable <= 1'b0;
      rf_wreg   <= '0;
      rf_wdata  <= '0;
      stall_req <= 1'b0;
      starve_q  <= '0;
    end else begin
      stall_req <= 1'b0;
      case (src)
        SRC_PIPE: begin
          rf_enable <= 1'b1;
          rf_wreg   <= pipe_wreg;
          rf_wdata  <= pipe_wdata;
          if (!q_any_valid) begin
            starve_q <= '0;
          end else if (starve_q == SW'(STARVE_LIMIT - 1)) begin
            stall_req <= 1'b1;
            starve_q  <= '0;
          end else begin
            starve_q <= starve_q + SW'(1);
          end
        end
        SRC_QUEUE: begin
          rf_enable <= q_head_valid;
          if (q_head_valid) begin
            rf_wreg  <= q_head_wreg;
            rf_wdata <= q_head_wdata;
          end
          starve_q <= '0;
        end
        default: begin
          rf_enable <= 1'b0;
          starve_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_wb_arbiter;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int QDEPTH = 4;
  localparam int LIMIT  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_wreg;
  logic [31:0] pipe_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wreg;
  logic [31:0] lu_wdata;
  logic [4:0]  pend_qreg;
  logic        pend_hit;
  logic        stall_req;
  logic        rf_enable;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;

  wb_arbiter #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .QDEPTH       (QDEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_we    (pipe_we),
    .pipe_wreg  (pipe_wreg),
    .pipe_wdata (pipe_wdata),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_wreg    (lu_wreg),
    .lu_wdata   (lu_wdata),
    .pend_qreg  (pend_qreg),
    .pend_hit   (pend_hit),
    .stall_req  (stall_req),
    .rf_enable  (rf_enable),
    .rf_wreg    (rf_wreg),
    .rf_wdata   (rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  bit          m_stall;
  int          m_cnt;
  bit          m_rf_en;
  logic [4:0]  m_rf_wreg;
  logic [31:0] m_rf_wdata;

  int n_vec;
  int n_err;
  bit saw_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: one clock edge worth of write-back behaviour on the model queue.
  task automatic model_step();
    bit   ready;
    bit   anyv;
    bit   nst;
    ent_t h;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_stall    = 0;
      m_cnt      = 0;
      m_rf_en    = 0;
      m_rf_wreg  = '0;
      m_rf_wdata = '0;
      return;
    end
    ready = mq.size() < QDEPTH;
    anyv  = 0;
    nst   = 0;
    foreach (mq[i]) if (mq[i].v) anyv = 1;
    if (!m_stall && pipe_we && pipe_wreg != 0) begin
      m_rf_en    = 1;
      m_rf_wreg  = pipe_wreg;
      m_rf_wdata = pipe_wdata;
      foreach (mq[i]) if (mq[i].r == pipe_wreg) mq[i].v = 0;
      if (!anyv) m_cnt = 0;
      else if (m_cnt == LIMIT - 1) begin
        nst   = 1;
        m_cnt = 0;
      end else m_cnt++;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_rf_en = h.v;
      if (h.v) begin
        m_rf_wreg  = h.r;
        m_rf_wdata = h.d;
      end
      m_cnt = 0;
    end else begin
      m_rf_en = 0;
      m_cnt   = 0;
    end
    if (lu_valid && ready && lu_wreg != 0) begin
      e.v = 1;
      e.r = lu_wreg;
      e.d = lu_wdata;
      mq.push_back(e);
    end
    m_stall = nst;
  endtask

  task automatic step();
    bit exp_pend;
    #1;
    check("lu_ready", 64'(lu_ready), 64'(!reset && mq.size() < QDEPTH));
    exp_pend = 0;
    if (!reset && pend_qreg != 0) begin
      foreach (mq[i]) if (mq[i].v && mq[i].r == pend_qreg) exp_pend = 1;
      if (m_rf_en && m_rf_wreg == pend_qreg) exp_pend = 1;
    end
    check("pend_hit", 64'(pend_hit), 64'(exp_pend));
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (stall_req) saw_stall = 1;
    check("rf_enable", 64'(rf_enable), 64'(m_rf_en));
    if (m_rf_en) begin
      check("rf_wreg", 64'(rf_wreg), 64'(m_rf_wreg));
      check("rf_wdata", 64'(rf_wdata), 64'(m_rf_wdata));
    end
    check("stall_req", 64'(stall_req), 64'(m_stall));
  endtask

  task automatic drive(input bit r, input bit pwe, input logic [4:0] pr, input logic [31:0] pd,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ld,
                       input logic [4:0] pq);
    reset = r;
    if (!m_stall) begin
      pipe_we    = pwe;
      pipe_wreg  = pr;
      pipe_wdata = pd;
    end
    lu_valid  = lv;
    lu_wreg   = lr;
    lu_wdata  = ld;
    pend_qreg = pq;
    step();
  endtask

  task automatic idle(input int n, input logic [4:0] pq);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, pq);
  endtask

  initial begin
    n_vec = 0; n_err = 0; saw_stall = 0;
    m_stall = 0; m_cnt = 0; m_rf_en = 0; m_rf_wreg = '0; m_rf_wdata = '0;
    reset = 1; pipe_we = 0; pipe_wreg = 0; pipe_wdata = 0;
    lu_valid = 0; lu_wreg = 0; lu_wdata = 0; pend_qreg = 0;
    @(negedge clk);

    // reset held two cycles, then release
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 3, 32'h1234, 1, 4, 32'h55, 3);
    check("rst_wreg", 64'(rf_wreg), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);
    idle(1, 0);

    // single pipeline write
    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5);
    check("t2_en", 64'(rf_enable), 64'd1);
    check("t2_wreg", 64'(rf_wreg), 64'd5);
    check("t2_wdata", 64'(rf_wdata), 64'hDEADBEEF);

    // back-to-back long-latency results drain in order
    drive(0, 0, 0, 0, 1, 7, 32'h11, 7);
    drive(0, 0, 0, 0, 1, 8, 32'h22, 8);
    check("t3_first", 64'(rf_wreg), 64'd7);
    drive(0, 0, 0, 0, 0, 0, 0, 8);
    check("t3_second", 64'(rf_wreg), 64'd8);
    check("t3_second_d", 64'(rf_wdata), 64'h22);
    idle(2, 0);

    // fill the queue behind a busy pipe until starvation forces a stall
    for (int k = 0; k < 14; k++)
      drive(0, 1, 5'(24 + k % 4), $urandom, 1, 5'(10 + k), $urandom, 5'(10 + k % 4));
    check("t4_stall_seen", 64'(saw_stall), 64'd1);
    idle(8, 0);

    // pipe write squashes an older queued result to the same register
    drive(0, 1, 3, 32'h33, 1, 9, 32'hAA, 9);
    drive(0, 1, 9, 32'hBB, 0, 0, 0, 9);
    check("t5_wdata", 64'(rf_wdata), 64'hBB);
    idle(2, 9);
    #1;
    check("t5_pend_clear", 64'(pend_hit), 64'd0);
    @(negedge clk);

    // writes to $0 never reach the register file
    drive(0, 1, 0, 32'hF00D, 1, 0, 32'hBEEF, 0);
    check("t6_zero", 64'(rf_enable), 64'd0);
    idle(2, 0);

    // reset while results are queued discards them
    drive(0, 1, 20, 32'h1, 1, 14, 32'h2, 14);
    drive(0, 1, 21, 32'h3, 1, 15, 32'h4, 15);
    drive(1, 0, 0, 0, 0, 0, 0, 14);
    idle(3, 15);
    check("t6_no_stale", 64'(rf_enable), 64'd0);

    // random traffic over a small register set to provoke squashes and hits
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
            $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
